// File: rtl/apple_placer_if.sv
// Bundle of the apple placer's game-side handshake, generator and occupancy-query signals.
// master is the placer itself; slave is whatever surrounds it (game FSM, LFSR, body map).
interface apple_placer_if;
    logic       req;
    logic       busy;
    logic       lfsr_tick;
    logic [7:0] rnd_x;
    logic [6:0] rnd_y;
    logic       occ_qv;
    logic [7:0] occ_qx;
    logic [6:0] occ_qy;
    logic       occ_hit;
    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic       done;
    logic       fail;

    modport master (
        input  req, rnd_x, rnd_y, occ_hit,
        output busy, lfsr_tick, occ_qv, occ_qx, occ_qy, apple_x, apple_y, done, fail
    );

    modport slave (
        output req, rnd_x, rnd_y, occ_hit,
        input  busy, lfsr_tick, occ_qv, occ_qx, occ_qy, apple_x, apple_y, done, fail
    );
endinterface

// File: rtl/apple_placer.sv
// Draws random cells from the LFSR, folds them into the playfield and retries until a free cell is found.
// Define APPLE_SCAN_FALLBACK_EN to fall back to a raster scan of the grid once the random tries run out.
module apple_placer #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_TRIES = 16
) (
    input  logic          clk,
    input  logic          rst,
    apple_placer_if.master bus
);
    localparam logic [7:0] W         = 8'(GRID_W);
    localparam logic [6:0] H         = 7'(GRID_H);
    localparam logic [8:0] TRIES_LIM = 9'(MAX_TRIES);
`ifdef APPLE_SCAN_FALLBACK_EN
    localparam logic [7:0] X_LAST    = 8'(GRID_W - 1);
    localparam logic [6:0] Y_LAST    = 7'(GRID_H - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADV,
        S_SAMPLE,
        S_REDUCE,
        S_QUERY,
        S_WAIT,
        S_DONE,
        S_FAIL
`ifdef APPLE_SCAN_FALLBACK_EN
        ,
        S_SQUERY,
        S_SWAIT
`endif
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] cx_reg;
    logic [6:0] cy_reg;
    logic [7:0] tries_reg;
    logic [7:0] apple_x_reg;
    logic [6:0] apple_y_reg;

    logic       x_in_range;
    logic       y_in_range;
    logic [8:0] tries_inc;
    logic       exhausted;
`ifdef APPLE_SCAN_FALLBACK_EN
    logic       scan_last;
`endif

    logic       busy_next;
    logic       tick_next;
    logic       qv_next;
    logic       done_next;
    logic       fail_next;

    assign x_in_range = (cx_reg < W);
    assign y_in_range = (cy_reg < H);
    assign tries_inc  = {1'b0, tries_reg} + 9'd1;
    // >= rather than == keeps an out-of-range MAX_TRIES from looping forever.
    assign exhausted  = (tries_inc >= TRIES_LIM);
`ifdef APPLE_SCAN_FALLBACK_EN
    assign scan_last  = (cx_reg == X_LAST) && (cy_reg == Y_LAST);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.req) state_next = S_ADV;
            S_ADV:    state_next = S_SAMPLE;
            S_SAMPLE: state_next = S_REDUCE;
            S_REDUCE: if (x_in_range && y_in_range) state_next = S_QUERY;
            S_QUERY:  state_next = S_WAIT;
            S_WAIT: begin
                if (!bus.occ_hit) begin
                    state_next = S_DONE;
                end else if (!exhausted) begin
                    state_next = S_ADV;
                end else begin
`ifdef APPLE_SCAN_FALLBACK_EN
                    state_next = S_SQUERY;
`else
                    state_next = S_FAIL;
`endif
                end
            end
`ifdef APPLE_SCAN_FALLBACK_EN
            S_SQUERY: state_next = S_SWAIT;
            S_SWAIT: begin
                if (!bus.occ_hit) begin
                    state_next = S_DONE;
                end else if (scan_last) begin
                    state_next = S_FAIL;
                end else begin
                    state_next = S_SQUERY;
                end
            end
`endif
            S_DONE:   state_next = S_IDLE;
            S_FAIL:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode: every strobe is a pure function of the current state.
    always_comb begin
        busy_next = (state_reg != S_IDLE);
        tick_next = (state_reg == S_ADV);
        qv_next   = (state_reg == S_QUERY);
`ifdef APPLE_SCAN_FALLBACK_EN
        qv_next   = qv_next || (state_reg == S_SQUERY);
`endif
        done_next = (state_reg == S_DONE);
        fail_next = (state_reg == S_FAIL);
    end

    // Working coordinates, try counter and the placed apple.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_reg      <= '0;
            cy_reg      <= '0;
            tries_reg   <= '0;
            apple_x_reg <= '0;
            apple_y_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req) tries_reg <= '0;
                end
                S_SAMPLE: begin
                    cx_reg <= bus.rnd_x;
                    cy_reg <= bus.rnd_y;
                end
                S_REDUCE: begin
                    // Repeated subtraction in place of a divider; both axes fold in parallel.
                    if (!x_in_range) cx_reg <= cx_reg - W;
                    if (!y_in_range) cy_reg <= cy_reg - H;
                end
                S_WAIT: begin
                    if (!bus.occ_hit) begin
                        apple_x_reg <= cx_reg;
                        apple_y_reg <= cy_reg;
                    end else if (!exhausted) begin
                        tries_reg <= tries_inc[7:0];
                    end else begin
`ifdef APPLE_SCAN_FALLBACK_EN
                        cx_reg <= '0;
                        cy_reg <= '0;
`endif
                    end
                end
`ifdef APPLE_SCAN_FALLBACK_EN
                S_SWAIT: begin
                    if (!bus.occ_hit) begin
                        apple_x_reg <= cx_reg;
                        apple_y_reg <= cy_reg;
                    end else if (!scan_last) begin
                        // Raster order, x fastest.
                        if (cx_reg == X_LAST) begin
                            cx_reg <= '0;
                            cy_reg <= cy_reg + 7'd1;
                        end else begin
                            cx_reg <= cx_reg + 8'd1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_next;
    assign bus.lfsr_tick = tick_next;
    assign bus.occ_qv    = qv_next;
    assign bus.occ_qx    = cx_reg;
    assign bus.occ_qy    = cy_reg;
    assign bus.apple_x   = apple_x_reg;
    assign bus.apple_y   = apple_y_reg;
    assign bus.done      = done_next;
    assign bus.fail      = fail_next;
endmodule

// File: doc/apple_placer.md
# apple_placer

Consumes pseudo-random coordinates from the LFSR apple generator and produces a legal apple position for the game core. It reduces the raw coordinates into the playfield, asks the snake-body occupancy logic whether that cell is free, and retries with a fresh random draw on collision. The block sits between the apple generator (it drives the generator's `tick`) and the game-state FSM (it answers `req` with `done` or `fail`).

## Interface
- `GRID_W`, default 40: playfield width in cells. Legal range 1..255.
- `GRID_H`, default 30: playfield height in cells. Legal range 1..127.
- `MAX_TRIES`, default 16: random draws allowed before exhaustion handling. Legal range 1..255.
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  1: request a new apple. Sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `lfsr_tick`  out  1: one-cycle strobe to the generator's `tick`.
- `rnd_x`  in  8: generator X output (`ax`).
- `rnd_y`  in  7: generator Y output (`ay`).
- `occ_qv`  out  1: occupancy query strobe, one cycle wide.
- `occ_qx`  out  8: query X. Held stable from QUERY through WAIT.
- `occ_qy`  out  7: query Y. Held stable from QUERY through WAIT.
- `occ_hit`  in  1: cell occupied. Valid in the cycle after `occ_qv`.
- `apple_x`  out  8: placed apple X. Registered; holds its value between placements.
- `apple_y`  out  7: placed apple Y. Registered; holds its value between placements.
- `done`  out  1: one-cycle pulse when `apple_x`/`apple_y` update.
- `fail`  out  1: one-cycle pulse when no free cell was found.

## Operation
- **Reset:** all outputs are 0, the state is IDLE and the try counter is 0. An asserted `rst` aborts any operation in progress immediately; no `done` or `fail` is issued for the aborted request.
- **IDLE:**
  - With `req`=1, clear the try counter and go to ADV.
  - `req` is ignored while `busy`=1; it is not queued.
- **ADV:** `lfsr_tick`=1 for exactly this cycle, then go to SAMPLE.
- **SAMPLE:** capture `rnd_x`/`rnd_y` (the post-shift generator value) into working registers cx/cy, then go to REDUCE.
- **REDUCE:**
  - Each cycle: if cx≥GRID_W then cx←cx−GRID_W; if cy≥GRID_H then cy←cy−GRID_H. Both subtractions happen in parallel.
  - When cx<GRID_W and cy<GRID_H at the start of a cycle, go to QUERY.
  - k = max(floor(rnd_x/GRID_W), floor(rnd_y/GRID_H)) subtraction cycles are needed, so REDUCE lasts k+1 cycles.
  - All comparisons are unsigned, 8-bit for X and 7-bit for Y.
- **QUERY:** `occ_qv`=1 with `occ_qx`=cx and `occ_qy`=cy, then go to WAIT.
- **WAIT:** sample `occ_hit`.
  - `occ_hit`=0: load cx/cy into `apple_x`/`apple_y`, pulse `done` in the next cycle, go to IDLE.
  - `occ_hit`=1 and tries+1<MAX_TRIES: increment tries and go to ADV.
  - `occ_hit`=1 and tries+1=MAX_TRIES: exhausted. Go to SCAN (macro defined) or pulse `fail` and go to IDLE (macro undefined).
- **SCAN (optional):**
  - Set cx=cy=0, then step through the grid in raster order (x fastest) using a 2-cycle QUERY/WAIT per cell.
  - The first free cell is placed exactly as in WAIT, followed by `done`.
  - If the last cell (GRID_W−1, GRID_H−1) reports a hit, pulse `fail`.
- **Output exclusivity:** `done` and `fail` are never high together, and neither is ever high while in IDLE except as the terminating pulse.

## Timing
- Take edge E0 as the edge that samples `req`=1. Then:
  - `lfsr_tick` is high in cycle E0+1.
  - `occ_qv` is high in cycle E0+4+k.
  - `done` is high in cycle E0+6+k, with no collision.
- Each collision retry adds 5+k' cycles, where k' is the reduction count of the new draw.
- A scan costs 2 cycles per cell visited, plus 1 cycle for the `done`/`fail` pulse.
- `apple_x`/`apple_y` change in the same cycle `done` rises.
- `busy` falls in the cycle after `done`/`fail`.
- A new `req` is accepted at the earliest one cycle after `done`/`fail`.

## Configuration
- Macro: `APPLE_SCAN_FALLBACK_EN`.
- Defined: exhaustion runs the deterministic raster scan. `fail` is issued only when the grid is completely full.
- Undefined: SCAN logic is absent. Exhaustion pulses `fail` one cycle after the final WAIT, and `apple_x`/`apple_y` keep their previous values.

## Test plan
- **Reset values:** assert `rst` mid-REDUCE → all outputs read 0 within the same cycle. Release `rst` → IDLE, and no `done`.
- **Clean first placement:** generator at reset seed 0xACE1, GRID 40×30, empty board, `req` pulse → one `lfsr_tick`, sampled (195,89), k=4, query (35,29), `done` at E0+10, apple=(35,29).
- **Retry path:** `occ_hit`=1 for the first query only → exactly two `lfsr_tick` pulses, two `occ_qv` pulses, then `done` with the second draw's reduced coordinate.
- **Exhaustion, macro undefined:** MAX_TRIES=3, `occ_hit` always 1 → 3 queries, then `fail` one cycle after the 3rd WAIT. Apple unchanged.
- **Scan fallback, macro defined:** GRID 4×2, MAX_TRIES=1, occupied everywhere except (2,1) → scan queries (0,0)…(2,1) in order, `done` with apple=(2,1). With the grid fully occupied → `fail` after the (3,1) query.
- **Request while busy:** pulse `req` during REDUCE → ignored. Exactly one `done`, and only one `lfsr_tick` per draw.
